shift_rows: RTL and testbench
=============================

# shift_rows

AES ShiftRows stage with a registered output. It cyclically rotates each row of the 4x4 AES byte state: left for encryption, right for decryption. Direction is fixed at elaboration time. The block sits in the AES round datapath between SubBytes and MixColumns (encrypt), or between InvMixColumns/AddRoundKey and InvSubBytes (decrypt).

## Interface
Parameters:
- enc_dec, default 0: direction. 0 = encryption ShiftRows; 1 = decryption InvShiftRows. Any other value is illegal and must fail elaboration.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  qualifies state on this cycle.
- state  input  [0:127]  input AES state, big-endian byte order.
- out_valid  output  1  qualifies new_state.
- new_state  output  [0:127]  shifted AES state, registered.

## Operation
- Byte k (k = 0..15) occupies bits [8k : 8k+7]. Bit 0 is the MSB of byte 0.
- Layout is column-major, as in FIPS-197: byte k = row r, column c, where k = 4c + r.
- Encrypt (enc_dec=0): out[4c+r] = in[4*((c+r) mod 4) + r]. Row r rotates left by r bytes.
- Decrypt (enc_dec=1): out[4c+r] = in[4*((c−r) mod 4) + r]. Row r rotates right by r bytes.
- Row 0 passes through unchanged in both modes.
- The operation is a pure byte permutation: no arithmetic, and bits inside a byte never reorder.
- Encrypt followed by decrypt is the identity for every input.

## Timing
- Reset: when rst_n=0 at a rising edge, new_state <= 128'h0 and out_valid <= 0. Reset overrides in_valid on that same edge.
- Latency is exactly 1 cycle. If in_valid=1 at edge N, then after edge N, new_state = permute(state sampled at N) and out_valid = 1.
- If in_valid=0 at an edge (and not in reset): out_valid <= 0 and new_state holds its previous value.
- Back-to-back operation is supported: a new input is accepted every cycle, throughput 1 state per cycle.
- There is no backpressure and no ready signal. The downstream stage must sample out_valid on every cycle.
- Asserting reset mid-stream discards the in-flight result. The first valid output after reset release appears 1 cycle after the first accepted in_valid.
- Only new_state and out_valid are registered. The permutation is combinational wiring in front of the register, with no logic levels.

## Structure
- Shared AES package:
  - an aes_state_t typedef for the 128-bit state, [0:127];
  - an AES_ENC=0 / AES_DEC=1 constant pair;
  - a byte-index helper function idx(r,c) = 4c+r.
- The permutation is a generate loop over r, c in 0..3 inside the block. No sub-module is needed.
- The register stage (clk/rst_n process for new_state and out_valid) stays in the same module.

## Test plan
- FIPS-197 round-1 vector, enc_dec=0. Input d42711aee0bf98f1b8b45de51e415230 with in_valid=1 → one cycle later new_state = d4bf5d30e0b452aeb84111f11e2798e5 and out_valid=1.
- Index vector, enc_dec=0. Input 000102030405060708090a0b0c0d0e0f → 00050a0f04090e03080d02070c01060b.
- Index vector, enc_dec=1. Input 000102030405060708090a0b0c0d0e0f → 000d0a0704010e0b0805020f0c090603. Also, input 00050a0f04090e03080d02070c01060b → 000102030405060708090a0b0c0d0e0f, confirming the inverse.
- Reset and hold:
  - Hold rst_n=0 with in_valid=1 → new_state=0 and out_valid=0.
  - Release reset, then drive in_valid=0 → outputs stay 0.
  - Apply one valid input followed by in_valid=0 → out_valid pulses for 1 cycle and new_state holds the result.
- Streaming: send the three vectors above on consecutive cycles → the results appear on consecutive cycles, in order, with out_valid continuously high. Assert rst_n=0 mid-stream → the next edge clears both outputs.
- Randomized: run 1000 random states through an enc_dec=0 instance chained into an enc_dec=1 instance → the chain output equals the input after 2 cycles.

Source files
------------

// File: rtl/shift_rows_pkg.sv
// -----------------------------------------------------------------------------
// shift_rows_pkg
//   Shared AES definitions used by the ShiftRows stage.
//   - aes_state_t : 128-bit AES state, big-endian byte order, bit 0 = MSB of
//                   byte 0. Byte k occupies bits [8k : 8k+7].
//   - AES_ENC / AES_DEC : direction selectors for the enc_dec parameter.
//   - idx(r, c)   : byte index of row r, column c in the column-major state.
// -----------------------------------------------------------------------------
package shift_rows_pkg;

   typedef logic [0:127] aes_state_t;

   localparam int AES_ENC = 0;
   localparam int AES_DEC = 1;

   // Column-major layout: the four bytes of a column are contiguous.
   function automatic int idx(input int r, input int c);
      return 4 * c + r;
   endfunction

endpackage

// File: rtl/shift_rows.sv
// -----------------------------------------------------------------------------
// shift_rows
//   AES ShiftRows / InvShiftRows stage with a single register stage.
//   Row r of the 4x4 byte state rotates left by r bytes (enc_dec = AES_ENC)
//   or right by r bytes (enc_dec = AES_DEC). Row 0 passes through unchanged.
//
// Parameters
//   enc_dec   : AES_ENC (0) = ShiftRows, AES_DEC (1) = InvShiftRows.
//               Any other value stops elaboration.
//
// Ports
//   clk       : clock, all state updates on the rising edge.
//   rst_n     : synchronous active-low reset; clears new_state and out_valid.
//   in_valid  : state is valid on this cycle.
//   state     : input AES state, byte k at bits [8k : 8k+7].
//   out_valid : new_state carries a fresh result on this cycle.
//   new_state : permuted state, registered (1-cycle latency).
//
// Handshake: valid-only, no backpressure. An input is accepted on every rising
// edge where in_valid=1 and rst_n=1; its result appears after that edge with
// out_valid=1 for exactly one cycle per accepted input. The consumer must
// sample out_valid every cycle. When in_valid=0, new_state holds its last value.
// -----------------------------------------------------------------------------
module shift_rows
   import shift_rows_pkg::*;
#(
   parameter int enc_dec = AES_ENC
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [0:127] state,
   output logic         out_valid,
   output logic [0:127] new_state
);

   if ((enc_dec != AES_ENC) && (enc_dec != AES_DEC)) begin : g_bad_enc_dec
      $error("shift_rows: enc_dec must be 0 (encrypt) or 1 (decrypt)");
   end

   aes_state_t shifted;

   // Pure wiring: each output byte selects one input byte from the same row.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         localparam int src_col = (enc_dec == AES_ENC) ? ((c + r) % 4)
                                                       : ((c - r + 4) % 4);
         assign shifted[idx(r, c) * 8 +: 8] = state[idx(r, src_col) * 8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         new_state <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            new_state <= shifted;
         end
      end
   end

endmodule

// File: tb/tb_shift_rows.sv
// -----------------------------------------------------------------------------
// tb_shift_rows
//   Bench for shift_rows: an encrypt instance, a standalone decrypt instance,
//   and a decrypt instance chained behind the encrypt instance.
// -----------------------------------------------------------------------------
module tb_shift_rows;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // ---------------- DUT signals ----------------
   logic         enc_in_valid, enc_out_valid;
   logic [0:127] enc_state, enc_new_state;
   logic         dec_in_valid, dec_out_valid;
   logic [0:127] dec_state, dec_new_state;
   logic         chain_out_valid;
   logic [0:127] chain_new_state;

   shift_rows #(.enc_dec(0)) u_enc (
      .clk(clk), .rst_n(rst_n),
      .in_valid(enc_in_valid), .state(enc_state),
      .out_valid(enc_out_valid), .new_state(enc_new_state)
   );

   shift_rows #(.enc_dec(1)) u_dec (
      .clk(clk), .rst_n(rst_n),
      .in_valid(dec_in_valid), .state(dec_state),
      .out_valid(dec_out_valid), .new_state(dec_new_state)
   );

   shift_rows #(.enc_dec(1)) u_chain (
      .clk(clk), .rst_n(rst_n),
      .in_valid(enc_out_valid), .state(enc_new_state),
      .out_valid(chain_out_valid), .new_state(chain_new_state)
   );

   // ---------------- constants ----------------
   localparam logic [0:127] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [0:127] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [0:127] IDX      = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] IDX_ENC  = 128'h00050a0f04090e03080d02070c01060b;
   localparam logic [0:127] IDX_DEC  = 128'h000d0a0704010e0b0805020f0c090603;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [0:127] exp_enc_q[$];
   logic [0:127] exp_dec_q[$];
   logic [0:127] exp_chain_q[$];

   // Reference model: gather each row into a list, rotate the list, scatter.
   function automatic logic [0:127] ref_shift(input logic [0:127] s, input bit dec);
      logic [7:0]   row[$];
      logic [7:0]   b;
      logic [0:127] o;
      o = s;
      for (int r = 1; r < 4; r++) begin
         row.delete();
         for (int c = 0; c < 4; c++) row.push_back(s[(4 * c + r) * 8 +: 8]);
         for (int n = 0; n < r; n++) begin
            if (!dec) begin
               b = row.pop_front();
               row.push_back(b);
            end else begin
               b = row.pop_back();
               row.push_front(b);
            end
         end
         for (int c = 0; c < 4; c++) o[(4 * c + r) * 8 +: 8] = row[c];
      end
      return o;
   endfunction

   task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (enc_out_valid) begin
         if (exp_enc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL enc_unexpected: got out_valid=1 with %h, expected no output", enc_new_state);
         end else check("enc_stream", enc_new_state, exp_enc_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (dec_out_valid) begin
         if (exp_dec_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dec_unexpected: got out_valid=1 with %h, expected no output", dec_new_state);
         end else check("dec_stream", dec_new_state, exp_dec_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (chain_out_valid) begin
         if (exp_chain_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL chain_unexpected: got out_valid=1 with %h, expected no output", chain_new_state);
         end else check("chain_roundtrip", chain_new_state, exp_chain_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_enc(input logic [0:127] s);
      enc_in_valid = 1'b1;
      enc_state    = s;
      if (rst_n) begin
         exp_enc_q.push_back(ref_shift(s, 1'b0));
         exp_chain_q.push_back(s);
      end
   endtask

   task automatic send_dec(input logic [0:127] s);
      dec_in_valid = 1'b1;
      dec_state    = s;
      if (rst_n) exp_dec_q.push_back(ref_shift(s, 1'b1));
   endtask

   task automatic flush_expected();
      exp_enc_q.delete();
      exp_dec_q.delete();
      exp_chain_q.delete();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [0:127] r3_exp;

      // Reset held with valid inputs present.
      rst_n = 1'b0;
      send_enc(FIPS_IN);
      send_dec(IDX);
      tick();
      tick();
      @(negedge clk);
      check_bit("reset_enc_valid", enc_out_valid, 1'b0);
      check("reset_enc_state", enc_new_state, '0);
      check_bit("reset_dec_valid", dec_out_valid, 1'b0);
      check("reset_dec_state", dec_new_state, '0);

      // Release reset with no valid input.
      rst_n        = 1'b1;
      enc_in_valid = 1'b0;
      dec_in_valid = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check_bit("idle_enc_valid", enc_out_valid, 1'b0);
      check("idle_enc_state", enc_new_state, '0);
      check_bit("idle_chain_valid", chain_out_valid, 1'b0);

      // FIPS-197 vector: single pulse, then hold.
      send_enc(FIPS_IN);
      tick();
      enc_in_valid = 1'b0;
      @(negedge clk);
      check_bit("fips_valid", enc_out_valid, 1'b1);
      check("fips_state", enc_new_state, FIPS_OUT);
      tick();
      @(negedge clk);
      check_bit("pulse_valid_low", enc_out_valid, 1'b0);
      check("pulse_hold", enc_new_state, FIPS_OUT);

      // Decrypt index vector and inverse of the encrypted index vector.
      send_dec(IDX);
      tick();
      send_dec(IDX_ENC);
      @(negedge clk);
      check_bit("dec_idx_valid", dec_out_valid, 1'b1);
      check("dec_idx", dec_new_state, IDX_DEC);
      tick();
      dec_in_valid = 1'b0;
      @(negedge clk);
      check("dec_inverse", dec_new_state, IDX);
      tick();

      // Streaming three vectors back to back, then reset mid-stream.
      send_enc(FIPS_IN);
      tick();
      send_enc(IDX);
      @(negedge clk);
      check_bit("stream1_valid", enc_out_valid, 1'b1);
      check("stream1", enc_new_state, FIPS_OUT);
      tick();
      send_enc(IDX_ENC);
      r3_exp = ref_shift(IDX_ENC, 1'b0);
      @(negedge clk);
      check_bit("stream2_valid", enc_out_valid, 1'b1);
      check("stream2_idx", enc_new_state, IDX_ENC);
      tick();
      rst_n = 1'b0;
      send_enc(FIPS_IN);
      @(negedge clk);
      check_bit("stream3_valid", enc_out_valid, 1'b1);
      check("stream3", enc_new_state, r3_exp);
      tick();
      flush_expected();
      @(negedge clk);
      check_bit("midreset_valid", enc_out_valid, 1'b0);
      check("midreset_state", enc_new_state, '0);
      check_bit("midreset_chain_valid", chain_out_valid, 1'b0);
      check("midreset_chain_state", chain_new_state, '0);
      rst_n        = 1'b1;
      enc_in_valid = 1'b0;
      tick();
      tick();

      // Randomized traffic with occasional idle cycles.
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) != 0) send_enc({$urandom, $urandom, $urandom, $urandom});
         else enc_in_valid = 1'b0;
         if ($urandom_range(0, 1) != 0) send_dec({$urandom, $urandom, $urandom, $urandom});
         else dec_in_valid = 1'b0;
         tick();
      end
      enc_in_valid = 1'b0;
      dec_in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);

      check("enc_drain", 128'(exp_enc_q.size()), '0);
      check("dec_drain", 128'(exp_dec_q.size()), '0);
      check("chain_drain", 128'(exp_chain_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
